// File: rtl/spi_shift_if.sv
// Bus between the SPI register file/pads (master side) and spi_shift_engine (slave side).
// Carries the go/busy/done handshake, transfer configuration and the serial pins.
interface spi_shift_if #(
    parameter int MAX_LEN = 128,
    parameter int DIV_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
);
    logic               go;
    logic [LEN_W-1:0]   char_len;
    logic               lsb;
    logic               cpol;
    logic               cpha;
    logic [DIV_W-1:0]   divider;
    logic [MAX_LEN-1:0] tx_data;
    logic               miso;
    logic               sclk;
    logic               mosi;
    logic               busy;
    logic               done;
    logic [MAX_LEN-1:0] rx_data;

    modport master (
        output go, char_len, lsb, cpol, cpha, divider, tx_data, miso,
        input  sclk, mosi, busy, done, rx_data
    );

    modport slave (
        input  go, char_len, lsb, cpol, cpha, divider, tx_data, miso,
        output sclk, mosi, busy, done, rx_data
    );
endinterface

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI master shift engine: programmable length, divider, CPOL/CPHA and bit order.
// Define SPI_SHIFT_RX_EN to build the receive path; otherwise rx_data is constant 0.
module spi_shift_engine #(
    parameter int MAX_LEN = 128,
    parameter int DIV_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic           clk,
    input  logic           reset,
    spi_shift_if.slave     bus
);
    localparam int IDX_W = $clog2(MAX_LEN);

    typedef enum logic {IDLE, XFER} state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   tick_q, tick_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W:0]     edge_q, edge_d;
    logic               lsb_q, lsb_d;
    logic               cpha_q, cpha_d;
    logic [MAX_LEN-1:0] tx_sh_q, tx_sh_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   len_eff;
    logic [MAX_LEN-1:0] tx_norm;
    logic [LEN_W:0]     edge_num;
    logic               edge_odd, edge_last, edge_now, shift_now;

`ifdef SPI_SHIFT_RX_EN
    logic [MAX_LEN-1:0] rx_asm_q, rx_asm_d;
    logic [MAX_LEN-1:0] rx_data_q, rx_data_d;
    logic [LEN_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [IDX_W-1:0]   rx_idx;
    logic               sample_now;
`else
    logic               unused_miso;
    assign unused_miso = bus.miso;
`endif

    function automatic logic head_bit(input logic [MAX_LEN-1:0] v, input logic lsb_first);
        return lsb_first ? v[0] : v[MAX_LEN-1];
    endfunction

    function automatic logic [MAX_LEN-1:0] advance(input logic [MAX_LEN-1:0] v, input logic lsb_first);
        return lsb_first ? (v >> 1) : (v << 1);
    endfunction

    always_comb begin
        // NOTE: every *_d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        tick_d    = tick_q;
        div_d     = div_q;
        len_d     = len_q;
        edge_d    = edge_q;
        lsb_d     = lsb_q;
        cpha_d    = cpha_q;
        tx_sh_d   = tx_sh_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        shift_now = 1'b0;

        len_eff   = (bus.char_len == '0 || bus.char_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.char_len;
        // MSB-first words are left-aligned so the next bit is always at the top of the shifter.
        tx_norm   = bus.lsb ? bus.tx_data : (bus.tx_data << (LEN_W'(MAX_LEN) - len_eff));
        edge_now  = (tick_q == div_q);
        edge_num  = edge_q + (LEN_W+1)'(1);
        edge_odd  = edge_num[0];
        edge_last = (edge_num == {len_q, 1'b0});

`ifdef SPI_SHIFT_RX_EN
        rx_asm_d   = rx_asm_q;
        rx_data_d  = rx_data_q;
        rx_cnt_d   = rx_cnt_q;
        sample_now = 1'b0;
        rx_idx     = lsb_q ? IDX_W'(rx_cnt_q) : IDX_W'(len_q - LEN_W'(1) - rx_cnt_q);
`endif

        case (state_q)
            IDLE: begin
                sclk_d = bus.cpol;
                mosi_d = 1'b0;
                if (bus.go) begin
                    state_d = XFER;
                    tick_d  = '0;
                    edge_d  = '0;
                    div_d   = bus.divider;
                    len_d   = len_eff;
                    lsb_d   = bus.lsb;
                    cpha_d  = bus.cpha;
                    if (bus.cpha) begin
                        tx_sh_d = tx_norm;
                    end else begin
                        mosi_d  = head_bit(tx_norm, bus.lsb);
                        tx_sh_d = advance(tx_norm, bus.lsb);
                    end
`ifdef SPI_SHIFT_RX_EN
                    rx_asm_d = '0;
                    rx_cnt_d = '0;
`endif
                end
            end
            XFER: begin
                if (edge_now) begin
                    tick_d    = '0;
                    sclk_d    = ~sclk_q;
                    edge_d    = edge_num;
                    shift_now = cpha_q ? edge_odd : (!edge_odd && !edge_last);
`ifdef SPI_SHIFT_RX_EN
                    sample_now = cpha_q ? !edge_odd : edge_odd;
`endif
                end else begin
                    tick_d = tick_q + DIV_W'(1);
                end
                if (shift_now) begin
                    mosi_d  = head_bit(tx_sh_q, lsb_q);
                    tx_sh_d = advance(tx_sh_q, lsb_q);
                end
`ifdef SPI_SHIFT_RX_EN
                if (sample_now) begin
                    rx_asm_d[rx_idx] = bus.miso;
                    rx_cnt_d         = rx_cnt_q + LEN_W'(1);
                end
`endif
                // The final edge also carries the last trailing-edge sample when cpha=1.
                if (edge_now && edge_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
`ifdef SPI_SHIFT_RX_EN
                    rx_data_d = rx_asm_d;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            div_q   <= '0;
            len_q   <= '0;
            edge_q  <= '0;
            lsb_q   <= 1'b0;
            cpha_q  <= 1'b0;
            tx_sh_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_SHIFT_RX_EN
            rx_asm_q  <= '0;
            rx_data_q <= '0;
            rx_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
            state_q <= state_d;
            tick_q  <= tick_d;
            div_q   <= div_d;
            len_q   <= len_d;
            edge_q  <= edge_d;
            lsb_q   <= lsb_d;
            cpha_q  <= cpha_d;
            tx_sh_q <= tx_sh_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
`ifdef SPI_SHIFT_RX_EN
            rx_asm_q  <= rx_asm_d;
            rx_data_q <= rx_data_d;
            rx_cnt_q  <= rx_cnt_d;
`endif
        end
    end

    assign bus.sclk = sclk_q;
    assign bus.mosi = mosi_q;
    assign bus.busy = (state_q == XFER);
    assign bus.done = done_q;
`ifdef SPI_SHIFT_RX_EN
    assign bus.rx_data = rx_data_q;
`else
    assign bus.rx_data = '0;
`endif
endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: vector table plus back-to-back and mid-transfer reset sequences.
// Expected serial bits and receive words are queued at go time and popped as the DUT produces them.
module tb_spi_shift_engine;
    localparam int MAX_LEN = 128;
    localparam int DIV_W   = 16;

    typedef enum logic [1:0] {M_LOOP, M_ONE, M_ZERO} miso_e;

    typedef struct {
        logic         cpol;
        logic         cpha;
        logic         lsb;
        logic [7:0]   char_len;
        logic [15:0]  div;
        logic [127:0] tx;
        miso_e        miso;
        int           exp_len;
        logic [127:0] exp_rx;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset;
    miso_e miso_mode;
    int    n_checks = 0;
    int    n_pass   = 0;

    logic         exp_bits[$];
    logic [127:0] exp_rx_q[$];
    vec_t         vecs[8];

    spi_shift_if #(.MAX_LEN(MAX_LEN), .DIV_W(DIV_W)) sif ();

    spi_shift_engine #(.MAX_LEN(MAX_LEN), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    assign sif.miso = (miso_mode == M_LOOP) ? sif.mosi : (miso_mode == M_ONE);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic apply(input vec_t v);
        sif.cpol     = v.cpol;
        sif.cpha     = v.cpha;
        sif.lsb      = v.lsb;
        sif.char_len = v.char_len;
        sif.divider  = v.div;
        sif.tx_data  = v.tx;
        miso_mode    = v.miso;
    endtask

    task automatic push_expect(input vec_t v);
        for (int k = 0; k < v.exp_len; k++)
            exp_bits.push_back(v.lsb ? v.tx[k] : v.tx[v.exp_len-1-k]);
`ifdef SPI_SHIFT_RX_EN
        exp_rx_q.push_back(v.exp_rx);
`else
        exp_rx_q.push_back('0);
`endif
    endtask

    // Entered at E0+1; returns at the done cycle (+1) after checking the whole transfer.
    task automatic monitor_xfer(input vec_t v);
        int   c = 0, edges = 0, first_edge = -1, spurious = 0;
        int   span, budget;
        logic prev_sclk, prev_mosi, finished;
        span     = 2 * v.exp_len * (int'(v.div) + 1);
        budget   = span + 8;
        finished = 1'b0;
        check("e0_busy", sif.busy, 1'b1);
        check("e0_sclk", sif.sclk, v.cpol);
        prev_sclk = sif.sclk;
        prev_mosi = sif.mosi;
        while (!finished && c < budget) begin
            @(posedge clk); #1;
            c++;
            if (sif.sclk !== prev_sclk) begin
                edges++;
                if (first_edge < 0) first_edge = c;
                if (((edges % 2) == 1) == (v.cpha == 1'b0)) begin
                    if (exp_bits.size() == 0) check("bit_queue_empty", 1'b0, 1'b1);
                    else check("mosi_bit", prev_mosi, exp_bits.pop_front());
                end
            end
            if (sif.busy && sif.done) spurious++;
            if (!sif.busy) begin
                finished = 1'b1;
                check("busy_cycles", c, span);
                check("done_at_end", sif.done, 1'b1);
                check("edge_count", edges, 2 * v.exp_len);
                check("first_edge", first_edge, int'(v.div) + 1);
                check("end_sclk", sif.sclk, v.cpol);
                check("end_mosi", sif.mosi, 1'b0);
                if (exp_rx_q.size() == 0) check("rx_queue_empty", 1'b0, 1'b1);
                else check("rx_data", sif.rx_data, exp_rx_q.pop_front());
            end
            prev_sclk = sif.sclk;
            prev_mosi = sif.mosi;
        end
        check("no_timeout", finished, 1'b1);
        check("no_early_done", spurious, 0);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        apply(v);
        sif.go = 1'b1;
        push_expect(v);
        @(posedge clk); #1;
        sif.go = 1'b0;
        monitor_xfer(v);
        @(posedge clk); #1;
        check("done_one_cycle", sif.done, 1'b0);
        check("idle_after_done", sif.busy, 1'b0);
    endtask

    initial begin
        vec_t va, vb, vc;
        // fields: cpol, cpha, lsb, char_len, div, tx, miso, exp_len, exp_rx
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd8,   16'd1, 128'hA5,       M_LOOP, 8,   128'hA5};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'd12,  16'd0, 128'h3C1,      M_ONE,  12,  128'hFFF};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'd0,   16'd0, 128'h8000_0000_0000_0000_0000_0000_0000_0001,
                    M_LOOP, 128, 128'h8000_0000_0000_0000_0000_0000_0000_0001};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'd8,   16'd2, 128'h5A,       M_ONE,  8,   128'hFF};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'd5,   16'd3, 128'h13,       M_LOOP, 5,   128'h13};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'd200, 16'd0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                    M_LOOP, 128, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'd1,   16'd0, 128'h1,        M_ONE,  1,   128'h1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 8'd16,  16'd1, 128'h1234_BEEF, M_LOOP, 16, 128'hBEEF};

        va = '{1'b0, 1'b0, 1'b0, 8'd4,  16'd0, 128'h9,    M_LOOP, 4,  128'h9};
        vb = '{1'b0, 1'b0, 1'b1, 8'd4,  16'd0, 128'h6,    M_LOOP, 4,  128'h6};
        vc = '{1'b0, 1'b0, 1'b0, 8'd16, 16'd1, 128'hBEEF, M_LOOP, 16, 128'hBEEF};

        reset = 1'b0;
        sif.go = 1'b0;
        apply(vecs[0]);
        sif.cpol = 1'b1;
        miso_mode = M_ONE;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", sif.sclk, 1'b0);
        check("rst_mosi", sif.mosi, 1'b0);
        check("rst_busy", sif.busy, 1'b0);
        check("rst_done", sif.done, 1'b0);
        check("rst_rx", sif.rx_data, '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_sclk_cpol", sif.sclk, 1'b1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back: go held across done; inputs changed and go pulsed mid-transfer.
        @(negedge clk);
        apply(va);
        sif.go = 1'b1;
        push_expect(va);
        @(posedge clk); #1;
        fork
            monitor_xfer(va);
            begin
                repeat (2) @(negedge clk);
                apply(vb);
                push_expect(vb);
            end
        join
        @(posedge clk); #1;
        sif.go = 1'b0;
        fork
            monitor_xfer(vb);
            begin
                repeat (2) @(negedge clk);
                sif.go = 1'b1;
                sif.tx_data = 128'hF;
                sif.char_len = 8'd7;
                sif.lsb = 1'b0;
                @(negedge clk);
                sif.go = 1'b0;
            end
        join
        @(posedge clk); #1;
        check("b2b_done_one_cycle", sif.done, 1'b0);
        check("b2b_idle", sif.busy, 1'b0);

        // Reset right after edge 5 of a 16-bit, divider=1 transfer.
        @(negedge clk);
        apply(vc);
        sif.go = 1'b1;
        @(posedge clk); #1;
        sif.go = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_sclk", sif.sclk, 1'b0);
        check("midrst_mosi", sif.mosi, 1'b0);
        check("midrst_busy", sif.busy, 1'b0);
        check("midrst_done", sif.done, 1'b0);
        check("midrst_rx", sif.rx_data, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_no_done", sif.done, 1'b0);
        end
        run_vec(vc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
